// File: rtl/arb_mux_reg.sv
// ---------------------------------------------------------------------------
// arb_mux_reg
//
// Chooses one of N_CH valid/ready input channels and captures its word into a
// single output register that uses a valid/ready handshake.
//   MODE 0 : the channel is chosen by the external 'select' index.
//   MODE 1 : round-robin arbitration that starts its scan at a rotating
//            pointer.
// The output register loads only when it is empty or being drained, so an
// input word and the drained word can be exchanged in the same cycle with no
// bubble. A saturating counter records completed output transfers.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   valid_i  : per-channel data valid             [N_CH]
//   data_i   : channel k at bits [k*WIDTH +: WIDTH]
//   ready_o  : per-channel accept, combinational   [N_CH]
//   select   : channel index, used in MODE 0 only  [SW]
//   data_o   : registered output data              [WIDTH]
//   valid_o  : data_o holds an unconsumed word
//   ready_i  : downstream accept
//   grant_o  : source channel of the current data_o [SW]
//   count_o  : completed output transfers, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module arb_mux_reg #(
   parameter int WIDTH = 32,
   parameter int N_CH  = 4,
   parameter int MODE  = 0,
   localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       valid_i,
   input  logic [N_CH*WIDTH-1:0] data_i,
   output logic [N_CH-1:0]       ready_o,
   input  logic [SW-1:0]         select,
   output logic [WIDTH-1:0]      data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [SW-1:0]         grant_o,
   output logic [15:0]           count_o
);

   logic [WIDTH-1:0] dataOut_q, dataOut_d;
   logic             validOut_q, validOut_d;
   logic [SW-1:0]    grant_q, grant_d;
   logic [SW-1:0]    ptr_q, ptr_d;
   logic [15:0]      count_q, count_d;

   logic [SW-1:0]    chSel;
   logic             chOk;
   logic             loadEn;
   logic             accept;
   logic [WIDTH-1:0] chData;

   // Returns (base + off) wrapped into 0..N_CH-1; works for channel counts
   // that are not a power of two, where a plain SW-bit add would not wrap.
   function automatic logic [SW-1:0] wrapIdx(input logic [SW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_CH) begin
         s = s - N_CH;
      end
      return SW'(s);
   endfunction

   // The register may take a new word when it is empty or its current word
   // is leaving this cycle.
   assign loadEn = !validOut_q || ready_i;

   // Channel choice. In MODE 0 the select index is used directly, and an
   // out-of-range index picks nothing. In MODE 1 the scan runs from the
   // highest offset down to offset 0 so that the requester closest to the
   // pointer is the one left assigned when the loop finishes.
   always_comb begin
      chSel = '0;
      chOk  = 1'b0;
      if (MODE == 0) begin
         chSel = select;
         chOk  = ({1'b0, select} < (SW+1)'(N_CH));
      end else begin
         for (int i = N_CH - 1; i >= 0; i--) begin
            if (valid_i[wrapIdx(ptr_q, i)]) begin
               chSel = wrapIdx(ptr_q, i);
               chOk  = 1'b1;
            end
         end
      end
   end

   // Only the chosen channel is offered the accept, and only when the
   // register can load. In MODE 0 this does not depend on valid_i. Reset
   // blocks every accept so no word slips in while rst_n is low.
   always_comb begin
      ready_o = '0;
      if (rst_n && chOk && loadEn) begin
         ready_o[chSel] = 1'b1;
      end
   end

   assign accept = rst_n && chOk && loadEn && valid_i[chSel];
   assign chData = data_i[int'(chSel)*WIDTH +: WIDTH];

   // Next-state logic for the output register, the round-robin pointer and
   // the transfer counter. When load is enabled but nothing is accepted,
   // valid drops while data and grant keep their last values. The pointer
   // moves past the winner only on an accept, and only in MODE 1.
   always_comb begin
      dataOut_d  = dataOut_q;
      validOut_d = validOut_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      if (loadEn) begin
         validOut_d = accept;
         if (accept) begin
            dataOut_d = chData;
            grant_d   = chSel;
            if (MODE == 1) begin
               ptr_d = (chSel == SW'(N_CH - 1)) ? '0 : chSel + 1'b1;
            end
         end
      end
      if (validOut_q && ready_i && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   // State registers. Reset clears everything at once, independent of the
   // clock, which also throws away any word still held in the register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dataOut_q  <= '0;
         validOut_q <= 1'b0;
         grant_q    <= '0;
         ptr_q      <= '0;
         count_q    <= '0;
      end else begin
         dataOut_q  <= dataOut_d;
         validOut_q <= validOut_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
      end
   end

   assign data_o  = dataOut_q;
   assign valid_o = validOut_q;
   assign grant_o = grant_q;
   assign count_o = count_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// ---------------------------------------------------------------------------
// tb_arb_mux_reg
//
// Drives one MODE 0 instance and one MODE 1 instance of arb_mux_reg
// (WIDTH=32, N_CH=4) with the same inputs. Each instance is checked every
// cycle against a behavioural model that works with integer channel numbers
// and modulo arithmetic. Directed sections cover the worked examples, and a
// randomized section follows them.
// ---------------------------------------------------------------------------
module tb_arb_mux_reg;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int SW = 2;

   logic             clk;
   logic             rstN;
   logic [N-1:0]     validI;
   logic [N*W-1:0]   dataI;
   logic [SW-1:0]    selectI;
   logic             readyI;

   logic [N-1:0]     rdyO  [2];
   logic [W-1:0]     dataO [2];
   logic             validO[2];
   logic [SW-1:0]    grantO[2];
   logic [15:0]      countO[2];

   int checks = 0;
   int errors = 0;

   // Behavioural model state, one entry per mode
   bit        mValid[2];
   logic [31:0] mData[2];
   int        mGrant[2];
   int        mCount[2];
   int        mPtr;
   int        chS[2];
   bit        ldS[2];

   arb_mux_reg #(.WIDTH(W), .N_CH(N), .MODE(0)) u_mode0 (
      .clk(clk), .rst_n(rstN), .valid_i(validI), .data_i(dataI),
      .ready_o(rdyO[0]), .select(selectI), .data_o(dataO[0]),
      .valid_o(validO[0]), .ready_i(readyI), .grant_o(grantO[0]),
      .count_o(countO[0])
   );

   arb_mux_reg #(.WIDTH(W), .N_CH(N), .MODE(1)) u_mode1 (
      .clk(clk), .rst_n(rstN), .valid_i(validI), .data_i(dataI),
      .ready_o(rdyO[1]), .select(selectI), .data_o(dataO[1]),
      .valid_o(validO[1]), .ready_i(readyI), .grant_o(grantO[1]),
      .count_o(countO[1])
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on a difference counts the failure and
   // reports the tag with observed and expected values.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Channel picked by the model: select index in MODE 0, otherwise the
   // first valid channel scanning from the pointer with wrap-around.
   function automatic int pickCh(input int m, input logic [N-1:0] v, input int sel);
      if (m == 0) begin
         if (sel < N) return sel;
         return -1;
      end
      for (int i = 0; i < N; i++) begin
         if (v[(mPtr + i) % N]) return (mPtr + i) % N;
      end
      return -1;
   endfunction

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         mValid[m] = 1'b0;
         mData[m]  = '0;
         mGrant[m] = 0;
         mCount[m] = 0;
      end
      mPtr = 0;
   endtask

   task automatic checkRegs();
      for (int m = 0; m < 2; m++) begin
         checkOutput($sformatf("valid_m%0d", m), 64'(validO[m]), 64'(mValid[m]));
         checkOutput($sformatf("data_m%0d", m),  64'(dataO[m]),  64'(mData[m]));
         checkOutput($sformatf("grant_m%0d", m), 64'(grantO[m]), 64'(mGrant[m]));
         checkOutput($sformatf("count_m%0d", m), 64'(countO[m]), 64'(mCount[m]));
      end
   endtask

   // Applies one cycle of inputs: checks the combinational ready against the
   // model, takes a clock edge, advances the model, then checks registers.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d,
                                input int sel, input logic rdy, input bit chk);
      validI  = v;
      dataI   = d;
      selectI = SW'(sel);
      readyI  = rdy;
      #1;
      for (int m = 0; m < 2; m++) begin
         logic [N-1:0] expR;
         chS[m] = pickCh(m, v, sel);
         ldS[m] = !mValid[m] || rdy;
         expR   = '0;
         if (rstN && ldS[m] && chS[m] >= 0) expR[chS[m]] = 1'b1;
         if (chk) checkOutput($sformatf("ready_m%0d", m), 64'(rdyO[m]), 64'(expR));
      end
      @(posedge clk);
      if (rstN) begin
         for (int m = 0; m < 2; m++) begin
            bit acc;
            acc = (chS[m] >= 0) && ldS[m] && v[chS[m]];
            if (mValid[m] && rdy && mCount[m] < 16'hFFFF) mCount[m]++;
            if (ldS[m]) begin
               mValid[m] = acc;
               if (acc) begin
                  mData[m]  = d[chS[m]*W +: W];
                  mGrant[m] = chS[m];
                  if (m == 1) mPtr = (chS[m] + 1) % N;
               end
            end
         end
      end
      #1;
      if (chk) checkRegs();
   endtask

   // Asserts reset between edges, checks the immediate clear, and releases
   // it away from the clock edge.
   task automatic doReset();
      rstN = 1'b0;
      #1;
      modelReset();
      checkRegs();
      for (int m = 0; m < 2; m++) checkOutput($sformatf("rst_ready_m%0d", m), 64'(rdyO[m]), 64'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
   endtask

   function automatic logic [N*W-1:0] allData(input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] c, input logic [31:0] e);
      return {e, c, b, a};
   endfunction

   initial begin
      int expGr[6];
      int expSp[4];
      logic [N*W-1:0] dA;
      logic [N*W-1:0] dDb;

      rstN    = 1'b1;
      validI  = '0;
      dataI   = '0;
      selectI = '0;
      readyI  = 1'b0;
      modelReset();
      #1;
      doReset();

      // External select walks channels 0..3, then a drain cycle.
      dA = allData(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'hF, dA, i, 1'b1, 1'b1);
         checkOutput("sel_data", 64'(dataO[0]), 64'(32'hA0 + i));
         checkOutput("sel_grant", 64'(grantO[0]), 64'(i));
      end
      applyStimulus(4'h0, dA, 0, 1'b1, 1'b1);
      checkOutput("sel_count", 64'(countO[0]), 64'd4);

      // Round-robin with every channel requesting.
      doReset();
      expGr = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'hF, dA, 0, 1'b1, 1'b1);
         checkOutput("rr_grant", 64'(grantO[1]), 64'(expGr[i]));
      end

      // Round-robin with only channels 1 and 3 requesting.
      doReset();
      expSp = '{1, 3, 1, 3};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1010, dA, 0, 1'b1, 1'b1);
         checkOutput("sparse_grant", 64'(grantO[1]), 64'(expSp[i]));
      end

      // Stall: load 0xDEADBEEF, then hold ready_i low while inputs churn.
      doReset();
      dDb = allData(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      applyStimulus(4'hF, dDb, 0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'(i + 5), allData($urandom, $urandom, $urandom, $urandom),
                       i + 1, 1'b0, 1'b1);
         checkOutput("stall_data", 64'(dataO[0]), 64'(32'hDEADBEEF));
         checkOutput("stall_grant", 64'(grantO[0]), 64'd0);
      end

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'($urandom), allData($urandom, $urandom, $urandom, $urandom),
                       int'($urandom_range(0, 3)), 1'(($urandom % 4) != 0), 1'b1);
      end

      // Reset in the middle of a stream, between clock edges.
      for (int i = 0; i < 3; i++) applyStimulus(4'hF, dA, i, 1'b1, 1'b1);
      #2;
      rstN = 1'b0;
      #1;
      modelReset();
      checkRegs();
      for (int m = 0; m < 2; m++) checkOutput($sformatf("mid_ready_m%0d", m), 64'(rdyO[m]), 64'd0);
      #2;
      rstN = 1'b1;
      applyStimulus(4'hF, dA, 0, 1'b1, 1'b1);
      checkOutput("post_rst_grant0", 64'(grantO[1]), 64'd0);
      applyStimulus(4'hF, dA, 0, 1'b1, 1'b1);
      checkOutput("post_rst_grant1", 64'(grantO[1]), 64'd1);

      // Counter saturation: more than 65536 back-to-back transfers.
      doReset();
      for (int i = 0; i < 65540; i++) applyStimulus(4'hF, dA, 0, 1'b1, 1'b0);
      applyStimulus(4'hF, dA, 0, 1'b1, 1'b1);
      checkOutput("sat_count_m0", 64'(countO[0]), 64'h0000_FFFF);
      checkOutput("sat_count_m1", 64'(countO[1]), 64'h0000_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb_mux_reg.md
ARB_MUX_REG -- requirements
Module: arb_mux_reg

Interface
REQ-001 SHALL have parameter WIDTH, 32, data width per channel (1..64).
REQ-002 SHALL have parameter N_CH, 4, input channel count (2..8).
REQ-003 SHALL have parameter MODE, 0, 0 = external select, 1 = round-robin arbitration.
REQ-004 SHALL define SW = max(1, clog2(N_CH)) as the select/grant width.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port valid_i  input  N_CH  per-channel data valid.
REQ-008 SHALL have port data_i  input  N_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port ready_o  output  N_CH  per-channel accept, combinational.
REQ-010 SHALL have port select  input  SW  channel index, used only in MODE 0.
REQ-011 SHALL have port data_o  output  WIDTH  registered output data.
REQ-012 SHALL have port valid_o  output  1  data_o holds an unconsumed word.
REQ-013 SHALL have port ready_i  input  1  downstream accept.
REQ-014 SHALL have port grant_o  output  SW  source channel of current data_o.
REQ-015 SHALL have port count_o  output  16  number of completed output transfers, saturating.

Function
REQ-016 SHALL define load_en = !valid_o || ready_i; output register loads only when load_en = 1.
REQ-017 SHALL, in MODE 0, choose ch = select; select >= N_CH SHALL select no channel (all ready_o = 0).
REQ-018 SHALL, in MODE 1, choose ch = first k with valid_i[k] = 1 scanning ptr, ptr+1, ... wrapping at N_CH-1 to 0.
REQ-019 SHALL drive ready_o[ch] = load_en and all other ready_o bits 0; ready_o SHALL not depend on valid_i in MODE 0.
REQ-020 SHALL accept a word when valid_i[ch] && ready_o[ch]; on accept: data_o <= channel ch data, grant_o <= ch, valid_o <= 1 on next edge.
REQ-021 SHALL give 1-cycle latency from input accept to valid_o = 1; full throughput of 1 word/cycle when ready_i held 1.
REQ-022 SHALL, when load_en = 1 and no word accepted, clear valid_o; data_o and grant_o SHALL hold last value.
REQ-023 SHALL, while valid_o && !ready_i, hold data_o, grant_o, valid_o stable and drive all ready_o 0.
REQ-024 SHALL, in MODE 1, update ptr <= (ch+1) mod N_CH only on accept; ptr SHALL hold otherwise; ptr SHALL be unused in MODE 0.
REQ-025 SHALL increment count_o on each cycle with valid_o && ready_i, saturating at 16'hFFFF.
REQ-026 SHALL treat select changes or valid_i drops during stall as having no effect until load_en = 1.
REQ-027 SHALL, on simultaneous drain and accept (valid_o && ready_i && accept), replace the word with no bubble and count the drained word.

Reset
REQ-028 SHALL, while rst_n = 0, force valid_o = 0, data_o = 0, grant_o = 0, ptr = 0, count_o = 0 immediately, independent of clk.
REQ-029 SHALL drive ready_o = 0 while rst_n = 0; a word held at reset assertion SHALL be discarded and not counted.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n rises.

Verification (WIDTH=32, N_CH=4)
REQ-031 SHALL cover MODE 0: I0..I3 = 0xA0,0xA1,0xA2,0xA3 all valid, ready_i = 1, select 0..3 per cycle -> data_o 0xA0..0xA3 one cycle later each, grant_o = select, count_o = 4.
REQ-032 SHALL cover MODE 1: all valid held, ready_i = 1 for 6 cycles -> grant_o sequence 0,1,2,3,0,1 (wrap 3 -> 0).
REQ-033 SHALL cover MODE 1 sparse: only valid_i = 4'b1010, ptr = 0 -> grants 1,3,1,3.
REQ-034 SHALL cover stall: valid_o = 1, data_o = 0xDEADBEEF, ready_i = 0 for 3 cycles while select/data_i change -> data_o, grant_o unchanged, ready_o = 0, count_o unchanged.
REQ-035 SHALL cover reset mid-stream: rst_n low between clock edges with valid_o = 1 -> valid_o, data_o, count_o = 0 immediately; after release MODE 1 grants start from channel 0.
REQ-036 SHALL cover count saturation: force 65537 transfers -> count_o = 0xFFFF, no wrap.
